// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO.
// One multiplier or quotient bit is resolved per CALC cycle. busy stalls
// the front of the pipeline while an operation is in flight.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  input  logic             wrHI,
  input  logic             wrLO,
  input  logic [WIDTH-1:0] wrVal,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]       state, nextState;
  logic [1:0]       opReg;
  logic [WIDTH-1:0] latA, latB;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] accHi, accLo;
  logic [CW-1:0]    cnt;
  logic             negQ, negR, zeroDiv;

  logic             isDiv, isSigned;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH-1:0] prod, prodFix;
  logic [WIDTH-1:0] quotFix, remFix;

  assign busy = (state != IDLE);

  // Next-state: flush wins over everything, start only honoured in IDLE
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start && !flush) nextState = PREP;
      PREP: nextState = CALC;
      CALC: if (cnt == '0) nextState = FIX;
      FIX:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (flush && state != IDLE) nextState = IDLE;
  end

  // Operand magnitudes, one iteration step for each algorithm, and sign fix-up
  always_comb begin
    isDiv    = opReg[1];
    isSigned = ~opReg[0];
    magA     = (isSigned && latA[WIDTH-1]) ? -latA : latA;
    magB     = (isSigned && latB[WIDTH-1]) ? -latB : latB;
    sum      = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
    shifted  = {accHi, accLo[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    prod     = {accHi, accLo};
    prodFix  = negQ ? -prod : prod;
    quotFix  = negQ ? -accLo : accLo;
    remFix   = negR ? -accHi : accHi;
  end

  // Controller state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Operand latch, sign bookkeeping and the shift-add / restoring datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opReg   <= '0;
      latA    <= '0;
      latB    <= '0;
      opnd    <= '0;
      accHi   <= '0;
      accLo   <= '0;
      cnt     <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      zeroDiv <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            opReg <= op;
            latA  <= opA;
            latB  <= opB;
          end
        end
        PREP: begin
          negQ    <= isSigned & (latA[WIDTH-1] ^ latB[WIDTH-1]);
          negR    <= isSigned & latA[WIDTH-1];
          zeroDiv <= isDiv & (latB == '0);
          accHi   <= '0;
          accLo   <= isDiv ? magA : magB;
          opnd    <= isDiv ? magB : magA;
          cnt     <= CW'(WIDTH - 1);
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!isDiv) begin
            accHi <= sum[WIDTH:1];
            accLo <= {sum[0], accLo[WIDTH-1:1]};
          end else if (!diff[WIDTH]) begin
            accHi <= diff[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], 1'b1};
          end else begin
            accHi <= shifted[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO plus the done/divZero pulses raised on FIX exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI      <= '0;
      LO      <= '0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      if (state == FIX && !flush) begin
        done    <= 1'b1;
        divZero <= zeroDiv;
        if (!isDiv) begin
          HI <= prodFix[2*WIDTH-1:WIDTH];
          LO <= prodFix[WIDTH-1:0];
        end else if (!zeroDiv) begin
          HI <= remFix;
          LO <= quotFix;
        end
      end else if (state == IDLE && !start) begin
        if (wrHI) HI <= wrVal;
        if (wrLO) LO <= wrVal;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for the multiply/divide sequencer.
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         reset, start, flush, wrHI, wrLO;
  logic [1:0]   op;
  logic [W-1:0] opA, opB, wrVal;
  logic         busy, done, divZero;
  logic [W-1:0] HI, LO;

  int compared = 0;
  int mismatched = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .wrHI(wrHI), .wrLO(wrLO), .wrVal(wrVal),
    .busy(busy), .done(done), .divZero(divZero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one start for a single cycle; called and returns on a falling edge
  task automatic applyStimulus(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = opc; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count remaining busy cycles, then check the result cycle
  task automatic finishOp(input string tag, input int expCycles,
                          input logic [W-1:0] expHi, input logic [W-1:0] expLo, input logic expDz);
    int cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, 64'(cycles), 64'(expCycles));
    checkOutput({tag, " done"}, 64'(done), 64'd1);
    checkOutput({tag, " divZero"}, 64'(divZero), 64'(expDz));
    checkOutput({tag, " HI"}, 64'(HI), 64'(expHi));
    checkOutput({tag, " LO"}, 64'(LO), 64'(expLo));
  endtask

  task automatic runOp(input string tag, input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expHi, input logic [W-1:0] expLo, input logic expDz);
    applyStimulus(opc, a, b);
    finishOp(tag, 34, expHi, expLo, expDz);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; flush = 1'b0; wrHI = 1'b0; wrLO = 1'b0;
    op = 2'b00; opA = '0; opB = '0; wrVal = '0;
    #12;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset HI", 64'(HI), 64'd0);
    checkOutput("reset LO", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    runOp("mult -3*5", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    runOp("multu", MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    runOp("divu back2back", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    @(negedge clk);
    runOp("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runOp("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);

    // Preload HI/LO, then divide by zero must leave them alone
    wrHI = 1'b1; wrVal = 32'h11;
    @(negedge clk);
    wrHI = 1'b0; wrLO = 1'b1; wrVal = 32'h22;
    @(negedge clk);
    wrLO = 1'b0;
    checkOutput("preload HI", 64'(HI), 64'h11);
    checkOutput("preload LO", 64'(LO), 64'h22);
    runOp("divu by 0", DIVU, 32'd7, 32'd0, 32'h11, 32'h22, 1'b1);
    @(negedge clk);

    // Flush mid-operation: busy drops, no done, HI/LO untouched
    applyStimulus(MULT, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush busy", 64'(busy), 64'd0);
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("flush done pulses", 64'(pulses), 64'd0);
    checkOutput("flush HI", 64'(HI), 64'h11);
    checkOutput("flush LO", 64'(LO), 64'h22);

    // MTHI while busy is ignored
    applyStimulus(MULTU, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    wrHI = 1'b1; wrVal = 32'hDEAD;
    @(negedge clk);
    wrHI = 1'b0;
    checkOutput("wrHI while busy", 64'(HI), 64'h11);
    finishOp("multu 6*7", 30, 32'd0, 32'd42, 1'b0);
    @(negedge clk);

    // Start while busy is dropped: exactly one done, first op's result
    applyStimulus(MULT, 32'd3, 32'd4);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 5) begin
        start = 1'b1; op = DIVU; opA = 32'd9; opB = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("start while busy pulses", 64'(pulses), 64'd1);
    checkOutput("start while busy HI", 64'(HI), 64'd0);
    checkOutput("start while busy LO", 64'(LO), 64'd12);

    // Reset mid-CALC clears everything without waiting for an edge
    applyStimulus(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset HI", 64'(HI), 64'd0);
    checkOutput("midreset LO", 64'(LO), 64'd0);
    checkOutput("midreset done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("after reset busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
